bit_serial_alu: RTL
===================

// Module: bit_serial_alu
// PURPOSE
//   Parametrised bit-serial add/subtract/negate unit, successor to the combinational ALU.
//   Processes one bit per clock, LSB first, in the style of the original Baby arithmetic.
//   Uses START/BUSY/DONE handshake, a held result register and a tri-state RESULT bus (OE_n).
//   Sits between the accumulator and store-data bus; serves SUB, LDN (negate) and pass-through.
// PARAMETERS
//   WIDTH   32   operand/result width in bits; legal range 2..64
//   CNT_W   $clog2(WIDTH)  bit-counter width; derived, never overridden
// PORTS
//   CLK      in   1      system clock, all state on rising edge
//   RESET_n  in   1      asynchronous, active-low reset
//   START    in   1      request; sampled only in IDLE
//   OP       in   2      00 ADD A+B, 01 SUB A-B, 10 NEG 0-B, 11 PASS B
//   A        in   WIDTH  operand A; captured on accepted START
//   B        in   WIDTH  operand B; captured on accepted START
//   OE_n     in   1      0 drives RESULT, 1 sets RESULT to high-Z (combinational, no clock)
//   BUSY     out  1      high while in SHIFT
//   DONE     out  1      one-cycle pulse when RESULT_REG updates
//   RESULT   out  WIDTH  RESULT_REG when OE_n=0, else all z
// BEHAVIOUR
//   Reset: state=IDLE, BUSY=0, DONE=0, RESULT_REG=0, count=0, carry=0; applies immediately, even mid-op.
//   FSM: IDLE -(START)-> SHIFT -(count==WIDTH-1)-> DONE_ST -> IDLE (unconditional).
//   Accept: edge where START=1 in IDLE; latch A, B and OP; set carry-in.
//     ADD: a=A, b=B, cin=0.  SUB: a=A, b=~B, cin=1.  NEG: a=0, b=~B, cin=1.  PASS: a=0, b=B, cin=0.
//   SHIFT: each cycle sum=a0^b0^c, c<=majority; shift a,b right; sum enters work-reg MSB.
//     Exactly WIDTH SHIFT cycles; BUSY=1 throughout.
//   DONE_ST: RESULT_REG<=work reg; DONE=1 for that single cycle; BUSY=0.
//   Latency: START accepted at edge k -> DONE high in cycle k+WIDTH+1 -> next START accepted at k+WIDTH+2.
//   START in SHIFT or DONE_ST is ignored, not queued. OP/A/B changes after accept do not affect the op.
//   RESULT_REG holds the previous result during SHIFT and changes only in DONE_ST.
//   Arithmetic: modulo 2^WIDTH; carry out of the MSB is discarded (see CONFIGURATION).
//   OE_n is independent of FSM; toggling it mid-operation neither stalls nor corrupts the operation.
// CONFIGURATION
//   Macro ALU_FLAGS_EN defined: extra outputs NEG_FLAG, ZERO_FLAG, CARRY_FLAG (1 bit each, not tri-stated).
//     They update in DONE_ST with RESULT_REG: NEG=MSB, ZERO=(result==0), CARRY=final carry out.
//     All reset to 0. NEG_FLAG feeds the CMP skip-if-negative path.
//   Macro ALU_FLAGS_EN undefined: flag ports and logic are absent; carry out is discarded.
// STRUCTURE
//   Shared package baby_alu_pkg: OP_ADD/OP_SUB/OP_NEG/OP_PASS codes, FSM state encodings
//     (ST_IDLE, ST_SHIFT, ST_DONE).
//   Sub-module serial_full_adder: 1-bit full adder plus carry flop.
//     Ports: CLK, RESET_n, LOAD, CIN_INIT, A_BIT, B_BIT, SUM, COUT.
//   Top contains the FSM, bit counter, operand shift registers, work register, RESULT_REG and tri-state.
// TESTING
//   WIDTH=32, ADD A=5, B=3, START 1 cycle -> BUSY 32 cycles, DONE at k+33, RESULT=0x00000008.
//   SUB A=5, B=0xA -> RESULT=0xFFFFFFFB; SUB A=0x64, B=0x64 -> 0x00000000 (ZERO_FLAG=1 if ALU_FLAGS_EN).
//   NEG B=7 -> 0xFFFFFFF9 (NEG_FLAG=1); PASS B=0x12345678 -> 0x12345678.
//   ADD 0x12345678+0x87654321 -> 0x99999999; OE_n=1 -> RESULT==z; OE_n=0 -> 0x99999999 again.
//   START pulsed mid-SHIFT with new operands -> ignored, single DONE, result of first op only.
//   RESET_n low at SHIFT cycle 10 -> BUSY=0, RESULT=0 immediately; after release, fresh ADD works.
//   WIDTH=8 instance: 0xFF+0x01 -> 0x00 after 8 shift cycles; CARRY_FLAG=1 if ALU_FLAGS_EN.

Source files
------------

// File: rtl/baby_alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation codes, FSM state
// encodings and the per-operation operand/carry-in setup.
package baby_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,   // A + B
        OP_SUB  = 2'b01,   // A - B
        OP_NEG  = 2'b10,   // 0 - B
        OP_PASS = 2'b11    // B
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // How an operation maps onto a plain serial adder.
    typedef struct packed {
        logic zero_a;   // replace A by 0
        logic inv_b;    // use ~B (two's complement with cin=1)
        logic cin;      // initial carry
    } op_ctrl_t;

    function automatic op_ctrl_t decode_op(input op_e op);
        op_ctrl_t c;
        c = '{zero_a: 1'b0, inv_b: 1'b0, cin: 1'b0};
        case (op)
            OP_ADD:  c = '{zero_a: 1'b0, inv_b: 1'b0, cin: 1'b0};
            OP_SUB:  c = '{zero_a: 1'b0, inv_b: 1'b1, cin: 1'b1};
            OP_NEG:  c = '{zero_a: 1'b1, inv_b: 1'b1, cin: 1'b1};
            OP_PASS: c = '{zero_a: 1'b1, inv_b: 1'b0, cin: 1'b0};
            default: c = '{zero_a: 1'b0, inv_b: 1'b0, cin: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_full_adder.sv
// One-bit full adder with a carry flop, used LSB first by bit_serial_alu.
// LOAD seeds the carry with CIN_INIT; otherwise the carry follows COUT.
module serial_full_adder (
    input  logic CLK,
    input  logic RESET_n,
    input  logic LOAD,
    input  logic CIN_INIT,
    input  logic A_BIT,
    input  logic B_BIT,
    output logic SUM,
    output logic COUT
);

    logic carry;

    assign SUM  = A_BIT ^ B_BIT ^ carry;
    assign COUT = (A_BIT & B_BIT) | (A_BIT & carry) | (B_BIT & carry);

    // Carry register: seeded at operation start, then ripples one bit per clock.
    // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            carry <= 1'b0;
        else if (LOAD)
            carry <= CIN_INIT;
        else
            carry <= COUT;
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial add/subtract/negate/pass unit, one bit per clock, LSB first.
// START/BUSY/DONE handshake, held result register, tri-state RESULT bus.
// Optional macro ALU_FLAGS_EN adds NEG_FLAG, ZERO_FLAG and CARRY_FLAG outputs.
module bit_serial_alu
    import baby_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             OE_n,
    output logic             BUSY,
    output logic             DONE,
    output wire  [WIDTH-1:0] RESULT
`ifdef ALU_FLAGS_EN
    ,
    output logic             NEG_FLAG,
    output logic             ZERO_FLAG,
    output logic             CARRY_FLAG
`endif
);

    state_e           state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-1:1] work;          // bits already produced; bit 0 of the result is the live sum
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] result_reg;
    logic             accept, last_bit, sum, cout;
    op_ctrl_t         ctrl;

    assign ctrl      = decode_op(op_e'(OP));
    assign accept    = (state == ST_IDLE) && START;
    assign last_bit  = (state == ST_SHIFT) && (count == CNT_W'(WIDTH - 1));
    assign work_next = {sum, work};

    serial_full_adder u_fa (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .LOAD     (accept),
        .CIN_INIT (ctrl.cin),
        .A_BIT    (a_sr[0]),
        .B_BIT    (b_sr[0]),
        .SUM      (sum),
        .COUT     (cout)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            ST_IDLE:  if (START) state_next = ST_SHIFT;
            ST_SHIFT: begin
                BUSY = 1'b1;
                if (last_bit) state_next = ST_DONE;
            end
            ST_DONE: begin
                DONE       = 1'b1;
                state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Operand capture, serial shifting, bit counter and result capture on the final bit.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            work       <= '0;
            count      <= '0;
            result_reg <= '0;
        end else if (accept) begin
            a_sr  <= ctrl.zero_a ? '0 : A;
            b_sr  <= ctrl.inv_b ? ~B : B;
            count <= '0;
        end else if (state == ST_SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            work  <= work_next[WIDTH-1:1];
            count <= count + CNT_W'(1);
            if (last_bit)
                result_reg <= work_next;
        end
    end

`ifdef ALU_FLAGS_EN
    // Status flags, updated together with the result register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            NEG_FLAG   <= 1'b0;
            ZERO_FLAG  <= 1'b0;
            CARRY_FLAG <= 1'b0;
        end else if (last_bit) begin
            NEG_FLAG   <= sum;
            ZERO_FLAG  <= (work_next == '0);
            CARRY_FLAG <= cout;
        end
    end
`else
    // Carry out of the MSB is discarded in this build.
`endif

    assign RESULT = OE_n ? {WIDTH{1'bz}} : result_reg;

endmodule
